// File: rtl/conv_encoder_k_if.sv
// Stream bundle for conv_encoder_k: bit input stream (s_*) and coded symbol stream (m_*).
// m_keep exists only when CONV_ENC_PUNCT_EN is defined.
interface conv_encoder_k_if #(
   parameter int N = 2
);
   logic         s_valid;
   logic         s_ready;
   logic         s_data;
   logic         s_last;
   logic         m_valid;
   logic         m_ready;
   logic [N-1:0] m_data;
   logic         m_last;
`ifdef CONV_ENC_PUNCT_EN
   logic [N-1:0] m_keep;

   // slave = encoder side, master = bit source / symbol sink side
   modport slave  (input  s_valid, s_data, s_last, m_ready,
                   output s_ready, m_valid, m_data, m_last, m_keep);
   modport master (output s_valid, s_data, s_last, m_ready,
                   input  s_ready, m_valid, m_data, m_last, m_keep);
`else
   modport slave  (input  s_valid, s_data, s_last, m_ready,
                   output s_ready, m_valid, m_data, m_last);
   modport master (output s_valid, s_data, s_last, m_ready,
                   input  s_ready, m_valid, m_data, m_last);
`endif
endinterface

// File: rtl/conv_encoder_k.sv
// Rate-1/N convolutional encoder, constraint length K, feed-forward or recursive systematic,
// with K-1 terminating tail symbols per frame. Define CONV_ENC_PUNCT_EN for the m_keep mask.
module conv_encoder_k #(
   parameter int              K   = 4,
   parameter int              N   = 2,
   parameter logic [N*K-1:0]  G   = 8'b1101_1111,
   parameter bit              RSC = 1'b0,
   parameter logic [K-1:0]    FB  = 4'b1011
`ifdef CONV_ENC_PUNCT_EN
   ,
   parameter int                   PUNCT_P   = 2,
   parameter logic [N*PUNCT_P-1:0] PUNCT_PAT = 4'b0111
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   conv_encoder_k_if.slave bus
);

   generate
      if (K < 3 || K > 9 || N < 2 || N > 4) begin : g_bad_param
         $error("conv_encoder_k: K must be 3..9 and N must be 2..4");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_TAIL = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [K-2:0] sr_q, sr_d;
   logic [N-1:0] data_q, data_d;
   logic         valid_q, valid_d;
   logic         last_q, last_d;
   logic [3:0]   cnt_q, cnt_d;

   logic         space_s;
   logic         load_s;
   logic         fb_s;
   logic         in_s;
   logic         u_s;
   logic [K-1:0] w_s;
   logic [N-1:0] sym_s;

   // Symbol computation and next-state logic
   always_comb begin
      space_s = !valid_q || bus.m_ready;
      load_s  = space_s && ((state_q == ST_TAIL) || bus.s_valid);
      fb_s    = RSC ? ^(FB[K-2:0] & sr_q) : 1'b0;
      // In the tail the input bit cancels the feedback, so zeros enter the register
      if (state_q == ST_TAIL) begin
         in_s = fb_s;
      end else begin
         in_s = bus.s_data;
      end
      u_s      = in_s ^ fb_s;
      w_s      = {u_s, sr_q};
      sym_s[0] = RSC ? in_s : ^(G[K-1:0] & w_s);
      for (int i = 1; i < N; i++) begin
         sym_s[i] = ^(G[i*K +: K] & w_s);
      end

      state_d = state_q;
      sr_d    = sr_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (load_s) begin
         sr_d    = {u_s, sr_q[K-2:1]};
         data_d  = sym_s;
         valid_d = 1'b1;
         last_d  = 1'b0;
         case (state_q)
            ST_IDLE, ST_RUN: begin
               state_d = bus.s_last ? ST_TAIL : ST_RUN;
            end
            ST_TAIL: begin
               if (cnt_q == 4'(K-2)) begin
                  state_d = ST_IDLE;
                  cnt_d   = 4'd0;
                  last_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (bus.m_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State, shift register and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.s_ready = (state_q != ST_TAIL) && space_s;
   assign bus.m_valid = valid_q;
   assign bus.m_data  = data_q;
   assign bus.m_last  = last_q;

`ifdef CONV_ENC_PUNCT_EN
   logic [N-1:0] keep_q, keep_d;
   logic [7:0]   p_q, p_d;
   logic [7:0]   p_use_s;

   // Puncture phase restarts with each frame's first data symbol; tail symbols keep all bits
   always_comb begin
      keep_d  = keep_q;
      p_d     = p_q;
      p_use_s = (state_q == ST_IDLE) ? 8'd0 : p_q;
      if (load_s) begin
         if (state_q == ST_TAIL) begin
            keep_d = {N{1'b1}};
         end else begin
            keep_d = PUNCT_PAT[int'(p_use_s)*N +: N];
            p_d    = (int'(p_use_s) + 1 >= PUNCT_P) ? 8'd0 : p_use_s + 8'd1;
         end
      end else begin
         keep_d = keep_q;
      end
   end

   // Keep mask and puncture phase registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keep_q <= '0;
         p_q    <= 8'd0;
      end else begin
         keep_q <= keep_d;
         p_q    <= p_d;
      end
   end

   assign bus.m_keep = keep_q;
`endif

endmodule
